// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: MD_* opcode encodings
// and small opcode classification helpers.
package muldiv_unit_pkg;

    localparam logic [2:0] MD_NOP   = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;
    localparam logic [2:0] MD_MF    = 3'd7;

    // Signed ops take operand magnitudes and sign-correct the result.
    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_md_neg.sv
// Conditional two's-complement negator; used for operand magnitudes and
// for the final sign correction of products, quotients and remainders.
module md_neg #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = neg ? (W'(0) - a) : a;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Multiplies and divides take 32 RUN cycles plus one FIX cycle; divide by
// zero skips RUN entirely.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clock,
    input  logic        rst_n,
    input  logic [2:0]  op,
    input  logic        sel_hi,
    input  logic        pause,
    input  logic [31:0] s,
    input  logic [31:0] t,
    output logic [31:0] res,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] w_q, w_d;          // {acc,multiplier} or {rem,quot}
    logic [31:0] b_q, b_d;          // multiplicand or divisor magnitude
    logic        is_div_q, is_div_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;

    logic        op_signed;
    logic [31:0] s_abs, t_abs;
    logic [63:0] mul_next, div_next;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh, rem_diff;
    logic        rem_ok;
    logic [63:0] mul_fix;
    logic [31:0] quot_fix, rem_fix;

    assign op_signed = md_is_signed(op);

    // Operand magnitudes; 0x80000000 stays 0x80000000 as an unsigned value.
    md_neg #(.W(32)) u_abs_s (.neg(op_signed & s[31]), .a(s), .y(s_abs));
    md_neg #(.W(32)) u_abs_t (.neg(op_signed & t[31]), .a(t), .y(t_abs));

    // Sign correction applied in FIX.
    md_neg #(.W(64)) u_fix_mul  (.neg(neg_quot_q), .a(w_q),        .y(mul_fix));
    md_neg #(.W(32)) u_fix_quot (.neg(neg_quot_q), .a(w_q[31:0]),  .y(quot_fix));
    md_neg #(.W(32)) u_fix_rem  (.neg(neg_rem_q),  .a(w_q[63:32]), .y(rem_fix));

    // One radix-2 step of each algorithm from the current working register.
    always_comb begin
        mul_sum  = {1'b0, w_q[63:32]} + (w_q[0] ? {1'b0, b_q} : 33'd0);
        mul_next = {mul_sum, w_q[31:1]};
        rem_sh   = w_q[63:31];
        rem_diff = rem_sh - {1'b0, b_q};
        rem_ok   = ~rem_diff[32];
        div_next = {(rem_ok ? rem_diff[31:0] : rem_sh[31:0]), w_q[30:0], rem_ok};
    end

    // Next-state logic: op acceptance, iteration and result write-back.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        w_d        = w_q;
        b_d        = b_q;
        is_div_d   = is_div_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (!pause) begin
                    case (op)
                        MD_MTHI: hi_d = s;
                        MD_MTLO: lo_d = s;
                        MD_MULT, MD_MULTU: begin
                            w_d        = {32'd0, s_abs};
                            b_d        = t_abs;
                            is_div_d   = 1'b0;
                            neg_quot_d = op_signed & (s[31] ^ t[31]);
                            neg_rem_d  = op_signed & s[31];
                            cnt_d      = 5'd0;
                            state_d    = S_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            is_div_d = 1'b1;
                            cnt_d    = 5'd0;
                            if (t == 32'd0) begin
                                // Preload the raw result; FIX passes it through.
                                w_d        = {s, 32'hFFFF_FFFF};
                                b_d        = 32'd0;
                                neg_quot_d = 1'b0;
                                neg_rem_d  = 1'b0;
                                state_d    = S_FIX;
                            end else begin
                                w_d        = {32'd0, s_abs};
                                b_d        = t_abs;
                                neg_quot_d = op_signed & (s[31] ^ t[31]);
                                neg_rem_d  = op_signed & s[31];
                                state_d    = S_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                w_d   = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = mul_fix[63:32];
                    lo_d = mul_fix[31:0];
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and architectural registers; busy is registered from next state.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            w_q        <= 64'd0;
            b_q        <= 32'd0;
            is_div_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            w_q        <= w_d;
            b_q        <= b_d;
            is_div_q   <= is_div_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign res  = sel_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// ops compared against an arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clock;
    logic        rst_n;
    logic [2:0]  op;
    logic        sel_hi;
    logic        pause;
    logic [31:0] s;
    logic [31:0] t;
    logic [31:0] res;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    muldiv_unit dut (
        .clock (clock),
        .rst_n (rst_n),
        .op    (op),
        .sel_hi(sel_hi),
        .pause (pause),
        .s     (s),
        .t     (t),
        .res   (res),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference result {hi,lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] oh,
                                               input logic [31:0] ol);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = {oh, ol};
        case (o)
            MD_MULT:  begin sp = sa * sb; r = sp; end
            MD_MULTU: begin up = ua * ub; r = up; end
            MD_DIV: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r = {sr[31:0], sq[31:0]};
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    up = ua / ub;
                    r[31:0] = up[31:0];
                    up = ua % ub;
                    r[63:32] = up[31:0];
                end
            end
            MD_MTHI: r = {a, ol};
            MD_MTLO: r = {oh, a};
            default: ;
        endcase
        return r;
    endfunction

    function automatic int ref_busy(input logic [2:0] o, input logic [31:0] b);
        if (o == MD_MULT || o == MD_MULTU) return 33;
        if (o == MD_DIV || o == MD_DIVU) return (b == 32'd0) ? 1 : 33;
        return 0;
    endfunction

    // Issue one op, count busy cycles, optionally disturb (1: extra MULT, 2: pause pulse).
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int dist_at, input int kind);
        logic [63:0] exp;
        int          cnt;
        exp = ref_result(o, a, b, model_hi, model_lo);
        @(negedge clock);
        op = o;
        s  = a;
        t  = b;
        @(negedge clock);
        op  = MD_NOP;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == dist_at && kind == 1) begin
                op = MD_MULT;
                s  = 32'h0000_0007;
                t  = 32'h0000_0009;
            end else if (cnt == dist_at && kind == 2) begin
                pause = 1'b1;
            end else begin
                op    = MD_NOP;
                pause = 1'b0;
            end
            if (cnt == 16) check({tag, " hold"}, {hi, lo}, {model_hi, model_lo});
            @(negedge clock);
        end
        op    = MD_NOP;
        pause = 1'b0;
        check({tag, " busy_cycles"}, 64'(cnt), 64'(ref_busy(o, b)));
        check({tag, " hilo"}, {hi, lo}, exp);
        model_hi = exp[63:32];
        model_lo = exp[31:0];
    endtask

    task automatic check_res(input string tag);
        sel_hi = 1'b1;
        #1;
        check({tag, " res_hi"}, 64'(res), 64'(model_hi));
        sel_hi = 1'b0;
        #1;
        check({tag, " res_lo"}, 64'(res), 64'(model_lo));
    endtask

    logic [2:0] rop;
    logic [31:0] ra, rb;

    initial begin
        rst_n  = 1'b0;
        op     = MD_NOP;
        sel_hi = 1'b0;
        pause  = 1'b0;
        s      = 32'd0;
        t      = 32'd0;
        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        @(negedge clock);
        rst_n = 1'b1;

        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0);
        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op("divu", MD_DIVU, 32'd100, 32'd7, 0, 0);
        run_op("divu_zero", MD_DIVU, 32'h0000_1234, 32'd0, 0, 0);
        run_op("div_zero_neg", MD_DIV, 32'hFFFF_FF00, 32'd0, 0, 0);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op("mthi", MD_MTHI, 32'hA5A5_A5A5, 32'd0, 0, 0);
        run_op("mtlo", MD_MTLO, 32'h5A5A_5A5A, 32'd0, 0, 0);
        check_res("mt");
        run_op("mult_ignored2", MD_MULT, 32'h0001_0003, 32'hFFFF_FFF5, 5, 1);
        run_op("mult_pause", MD_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 7, 2);
        check_res("mult_pause");

        // Op held while paused in IDLE must not be accepted.
        @(negedge clock);
        pause = 1'b1;
        op    = MD_MULTU;
        s     = 32'd2;
        t     = 32'd2;
        @(negedge clock);
        check("paused_idle busy", 64'(busy), 64'd0);
        op    = MD_NOP;
        pause = 1'b0;
        check("paused_idle hilo", {hi, lo}, {model_hi, model_lo});

        // Asynchronous reset in the middle of a run.
        @(negedge clock);
        op = MD_MULT;
        s  = 32'd3;
        t  = 32'd5;
        @(negedge clock);
        op = MD_NOP;
        repeat (10) @(negedge clock);
        rst_n = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst hilo", {hi, lo}, 64'd0);
        model_hi = 32'd0;
        model_lo = 32'd0;
        @(negedge clock);
        rst_n = 1'b1;
        repeat (3) @(negedge clock);
        check("postrst idle", 64'(busy), 64'd0);
        run_op("mult_after_rst", MD_MULT, 32'd3, 32'd5, 0, 0);

        // Random ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: rop = MD_MULT;
                1: rop = MD_MULTU;
                2: rop = MD_DIV;
                3: rop = MD_DIVU;
                4: rop = MD_MTHI;
                default: rop = MD_MTLO;
            endcase
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 7) == 0) rb = rb >> $urandom_range(16, 31);
            run_op($sformatf("rand%0d", i), rop, ra, rb, 0, 0);
        end
        check_res("rand_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
